// File: rtl/fifo_stream_drain.sv
// Drains an upstream BRAM FIFO into a ready/valid stream. Reads are credited against a skid
// buffer so that every read in flight always has a slot; m_last_o marks fixed-length bursts.
module fifo_stream_drain #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int SKID_DEPTH   = 4,
  parameter int BURST_LEN    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_wr_en_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + READ_LATENCY + 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(SKID_DEPTH - 1);
  localparam logic [CNT_W-1:0] CREDIT_LIM = CNT_W'(SKID_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [15:0]      BURST_MAX  = 16'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [READ_LATENCY-1:0] tag_r;
  logic [DATA_WIDTH-1:0]   skid_mem_r [SKID_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        occ_r;
  logic [CNT_W-1:0]        occ_nx_s;
  logic [CNT_W-1:0]        inflight_s;
  logic [15:0]             burst_cnt_r;
  logic                    rd_en_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    valid_s;
  logic                    drain_done_s;

  function automatic logic [CNT_W-1:0] tag_count(input logic [READ_LATENCY-1:0] tags);
    logic [CNT_W-1:0] acc;
    acc = CNT_ZERO;
    for (int i = 0; i < READ_LATENCY; i++) begin
      acc = acc + {{(CNT_W-1){1'b0}}, tags[i]};
    end
    return acc;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // The oldest tag marks the cycle in which the FIFO returns that read's data.
  assign inflight_s = tag_count(tag_r);
  assign push_s     = tag_r[READ_LATENCY-1];
  assign valid_s    = (occ_r != CNT_ZERO);
  assign pop_s      = valid_s & m_ready_i;

  // Read request: only while running, and only if a skid slot is reserved for the returning word.
  always_comb begin
    rd_en_s = 1'b0;
    if ((state_r == ST_RUN) && !fifo_empty_i && !fifo_wr_en_i &&
        ((inflight_s + occ_r) < CREDIT_LIM)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Skid occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    occ_nx_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_nx_s = occ_r + CNT_ONE;
      2'b01:   occ_nx_s = occ_r - CNT_ONE;
      default: occ_nx_s = occ_r;
    endcase
  end

  // Drain completes once nothing is in flight and the skid will be empty after this cycle,
  // so busy_o drops on the cycle following the final transfer.
  assign drain_done_s = (inflight_s == CNT_ZERO) && (occ_nx_s == CNT_ZERO);

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) state_nx_s = ST_RUN;
        else          state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable_i) state_nx_s = ST_DRAIN;
        else           state_nx_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (enable_i)          state_nx_s = ST_RUN;
        else if (drain_done_s) state_nx_s = ST_IDLE;
        else                   state_nx_s = ST_DRAIN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Read-tag shift register; reset discards every outstanding read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_r <= {READ_LATENCY{1'b0}};
    end else begin
      tag_r[0] <= rd_en_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Skid storage; cleared on reset so m_data_o reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      skid_mem_r[wr_ptr_r] <= fifo_data_i;
    end
  end

  // Skid pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      occ_r <= occ_nx_s;
    end
  end

  // Burst position; deliberately independent of the FSM so bursts span enable gaps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_cnt_r <= 16'd0;
    end else if (pop_s) begin
      if (burst_cnt_r == BURST_MAX) burst_cnt_r <= 16'd0;
      else                          burst_cnt_r <= burst_cnt_r + 16'd1;
    end
  end

  assign fifo_rd_en_o = rd_en_s;
  assign m_valid_o    = valid_s;
  assign m_data_o     = skid_mem_r[rd_ptr_r];
  assign m_last_o     = valid_s & (burst_cnt_r == BURST_MAX);
  assign busy_o       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain: behavioural BRAM FIFO with read latency, scoreboard of
// expected stream words and an independent burst-position model.
module tb_fifo_stream_drain;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int SD = 4;
  localparam int BL = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          fifo_empty_i;
  logic          fifo_wr_en_i;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_data_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          m_last_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  fifo_stream_drain #(.DATA_WIDTH(DW), .READ_LATENCY(RL), .SKID_DEPTH(SD), .BURST_LEN(BL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .fifo_empty_i(fifo_empty_i),
    .fifo_wr_en_i(fifo_wr_en_i), .fifo_rd_en_o(fifo_rd_en_o), .fifo_data_i(fifo_data_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .busy_o(busy_o)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          rdp_v[RL];
  logic [DW-1:0] rdp_d[RL];
  logic [DW-1:0] wr_word;
  logic          prev_hold;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int total, bad, cyc, beat;
  int rd_cnt, xfer_cnt, first_rd_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, first_last_at;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; xfer_cnt = 0; first_rd_cyc = -1; first_valid_cyc = -1;
    first_xfer_cyc = -1; last_xfer_cyc = -1; first_last_at = -1;
  endtask

  // One clock: settle, check and score this cycle's outputs, then advance the FIFO model.
  task automatic cycle();
    logic          rd_taken;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] w;
    rd_taken = 1'b0;
    rd_word  = '0;
    fifo_empty_i = (fifo_q.size() == 0);
    #1;
    chk("credit_bound", ((exp_q.size() - fifo_q.size()) <= SD), 1);
    if (fifo_wr_en_i) chk("rd_during_wr", fifo_rd_en_o, 0);
    if (prev_hold) begin
      chk("hold_valid", m_valid_o, 1);
      chk("hold_data", m_data_o, prev_data);
      chk("hold_last", m_last_o, prev_last);
    end
    if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid_o && m_ready_i) begin
      chk("word_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("data", m_data_o, w);
        chk("last", m_last_o, (beat == BL - 1));
        beat = (beat == BL - 1) ? 0 : beat + 1;
        xfer_cnt++;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        if (m_last_o && first_last_at < 0) first_last_at = xfer_cnt;
      end
    end
    prev_hold = m_valid_o & ~m_ready_i;
    prev_data = m_data_o;
    prev_last = m_last_o;
    if (fifo_rd_en_o) begin
      chk("rd_when_empty", (fifo_q.size() != 0), 1);
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (!fifo_wr_en_i && fifo_q.size() != 0) begin
        rd_taken = 1'b1;
        rd_word  = fifo_q.pop_front();
      end
    end
    @(posedge clk_i);
    #1;
    for (int i = RL - 1; i > 0; i--) begin
      rdp_v[i] = rdp_v[i-1];
      rdp_d[i] = rdp_d[i-1];
    end
    rdp_v[0] = rd_taken;
    rdp_d[0] = rd_word;
    if (fifo_wr_en_i) begin
      fifo_q.push_back(wr_word);
      exp_q.push_back(wr_word);
      wr_word = wr_word + 32'd1;
    end
    fifo_data_i = rdp_v[RL-1] ? rdp_d[RL-1] : {16'hBAD0, 16'(cyc)};
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run_to_empty(input string tag, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cycle();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    enable_i = 1'b0;
    while (busy_o && n < 50) begin
      cycle();
      n++;
    end
    chk(tag, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rem;
    total = 0; bad = 0; cyc = 0; beat = 0;
    wr_word = 32'h0000_8000;
    prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int i = 0; i < RL; i++) begin
      rdp_v[i] = 1'b0;
      rdp_d[i] = '0;
    end
    clear_stats();

    // Reset state, with requests that would otherwise start a drain
    rst_i = 1'b1; enable_i = 1'b1; m_ready_i = 1'b1; fifo_wr_en_i = 1'b0;
    fifo_empty_i = 1'b0; fifo_data_i = 32'h5A5A_5A5A;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_rd_en", fifo_rd_en_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", m_data_o, 0);
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) cycle();
    chk("idle_after_rst", busy_o, 0);

    // Streaming: 32 words, latency 3, one per cycle, last on 0x10 and 0x20
    clear_stats();
    load(32, 32'h1);
    enable_i = 1'b1; m_ready_i = 1'b1;
    run_to_empty("stream_done", 120);
    chk("stream_count", xfer_cnt, 32);
    chk("stream_latency", first_valid_cyc - first_rd_cyc, RL + 1);
    chk("stream_rate", last_xfer_cyc - first_xfer_cyc, 31);
    wait_idle("stream_idle");

    // Backpressure: 10 stalled cycles mid-stream
    clear_stats();
    load(32, 32'h100);
    enable_i = 1'b1; m_ready_i = 1'b1;
    repeat (8) cycle();
    m_ready_i = 1'b0;
    repeat (10) cycle();
    fifo_empty_i = (fifo_q.size() == 0);
    #1;
    chk("bp_rd_stopped", fifo_rd_en_o, 0);
    chk("bp_buffered", exp_q.size() - fifo_q.size(), SD);
    chk("bp_valid", m_valid_o, 1);
    m_ready_i = 1'b1;
    run_to_empty("bp_done", 120);
    chk("bp_count", xfer_cnt, 32);
    wait_idle("bp_idle");

    // Write collision: upstream writes on alternate cycles
    clear_stats();
    load(16, 32'h200);
    enable_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      fifo_wr_en_i = (i % 2 == 0);
      cycle();
    end
    fifo_wr_en_i = 1'b0;
    run_to_empty("wr_done", 120);
    chk("wr_count", xfer_cnt, 28);
    wait_idle("wr_idle");

    // Drain: enable drops with three reads in flight
    clear_stats();
    load(8, 32'h300);
    enable_i = 1'b1; m_ready_i = 1'b1;
    n = 0;
    while (rd_cnt < 2 && n < 20) begin
      cycle();
      n++;
    end
    enable_i = 1'b0;
    cycle();
    chk("drain_busy", busy_o, 1);
    n = 0;
    while (busy_o && n < 30) begin
      cycle();
      n++;
    end
    chk("drain_reads", rd_cnt, 3);
    chk("drain_words", xfer_cnt, 3);
    chk("drain_busy_fall", cyc, last_xfer_cyc + 1);
    chk("drain_left", fifo_q.size(), 5);
    enable_i = 1'b1;
    run_to_empty("drain_flush", 60);
    wait_idle("drain_idle");

    // Empty boundary: one word, exactly one read
    clear_stats();
    load(1, 32'h400);
    enable_i = 1'b1; m_ready_i = 1'b1;
    repeat (12) cycle();
    chk("empty_one_read", rd_cnt, 1);
    chk("empty_one_word", xfer_cnt, 1);
    wait_idle("empty_idle");

    // Reset mid-burst: burst count 5, two words buffered
    rem = (5 + BL - beat) % BL;
    load(rem + 2, 32'h500);
    enable_i = 1'b1; m_ready_i = 1'b1;
    n = 0;
    while (beat != 5 && n < 60) begin
      cycle();
      n++;
    end
    m_ready_i = 1'b0;
    repeat (8) cycle();
    chk("pre_rst_buffered", exp_q.size() - fifo_q.size(), 2);
    chk("pre_rst_valid", m_valid_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_last", m_last_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_data", m_data_o, 0);
    chk("mid_rst_rd_en", fifo_rd_en_o, 0);
    n = exp_q.size() - fifo_q.size();
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    beat = 0;
    prev_hold = 1'b0;
    m_ready_i = 1'b1;
    repeat (2) cycle();
    rst_i = 1'b0;
    clear_stats();
    repeat (4) cycle();
    chk("post_rst_silent", xfer_cnt, 0);
    load(20, 32'h600);
    run_to_empty("post_rst_done", 120);
    chk("post_rst_first_last", first_last_at, 16);
    wait_idle("post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
